alu_share_ctrl: RTL and testbench

//  Shares the single 32-bit ALU between two requesters (0 = execute path, 1 = address/branch path).

---
 rtl/alu_share_if.sv | 38 +++
 rtl/alu_share_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Request/response bundle between the two ALU requesters and alu_share_ctrl.
// Defining ALU_ZERO_FLAG_EN adds the rsp_zero response flag.
interface alu_share_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0;
  logic [2:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_err;
`ifdef ALU_ZERO_FLAG_EN
  logic        rsp_zero;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err, rsp_zero
  );
  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err, rsp_zero
  );
`else
  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err
  );
  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_err
  );
`endif
endinterface

// File: rtl/alu_share_ctrl.sv
// Arbitrates one shared 32-bit ALU between two requesters, one op in flight.
// Optional ALU_ZERO_FLAG_EN adds a registered rsp_zero flag on the response.
//
// state | meaning
// IDLE  | waiting for a request; req_ready driven for the granted requester
// EXEC  | ALU inputs held from regs for SETTLE cycles, result captured on the last
// RESP  | response presented to requester id_q until its rsp_ready
module alu_share_ctrl #(
  parameter int unsigned SETTLE      = 1,
  parameter bit          STRICT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_share_if.slave  bus,
  output logic [31:0] alu_in1_o,
  output logic [31:0] alu_in2_o,
  output logic        alu_binvert_o,
  output logic        alu_cin_o,
  output logic [1:0]  alu_operation_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_carry_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
  localparam logic [1:0] CNT_INIT = 2'(SETTLE - 1);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        id_q;
  logic [2:0]  op_q;
  logic [1:0]  cnt_q;
  logic [31:0] alu_in1_q, alu_in2_q;
  logic        alu_binvert_q, alu_cin_q;
  logic [1:0]  alu_operation_q;
  logic [31:0] rsp_result_q;
  logic        rsp_carry_q, rsp_err_q;
`ifdef ALU_ZERO_FLAG_EN
  logic        rsp_zero_q;
`endif

  logic        gnt, accept, rsp_hs;
  logic [2:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic [4:0]  sel_dec;
  logic [31:0] cap_result;
  logic        cap_carry, ovf, lt;

  // {legal, Binvert, Cin, Operation}
  function automatic logic [4:0] decode(input logic [2:0] op);
    case (op)
      3'b000:         decode = 5'b1_0_0_00;
      3'b001:         decode = 5'b1_0_0_01;
      3'b010:         decode = 5'b1_0_0_10;
      3'b110, 3'b111: decode = 5'b1_1_1_10;
      default:        decode = 5'b0_0_0_00;
    endcase
  endfunction

  always_comb begin
    gnt = 1'b0;
    case (bus.req_valid)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = STRICT_PRIO ? 1'b0 : ~last_grant_q;
      default: gnt = 1'b0;
    endcase
  end

  assign accept  = (state_q == IDLE) && (bus.req_valid != 2'b00);
  assign rsp_hs  = (state_q == RESP) && bus.rsp_ready[id_q];
  assign sel_op  = gnt ? bus.req_op1 : bus.req_op0;
  assign sel_a   = gnt ? bus.req_a1  : bus.req_a0;
  assign sel_b   = gnt ? bus.req_b1  : bus.req_b0;
  assign sel_dec = decode(sel_op);

  // SLT derives the signed compare from the subtract result and operand signs
  always_comb begin
    ovf        = (alu_in1_q[31] ^ alu_in2_q[31]) & (alu_result_i[31] ^ alu_in1_q[31]);
    lt         = alu_result_i[31] ^ ovf;
    cap_result = alu_result_i;
    cap_carry  = 1'b0;
    case (op_q)
      3'b010, 3'b110: cap_carry  = alu_carry_i;
      3'b111:         cap_result = {31'b0, lt};
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = sel_dec[4] ? EXEC : RESP;
      EXEC:    if (cnt_q == 2'd0) state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    case (state_q)
      IDLE:    if (accept) bus.req_ready = gnt ? 2'b10 : 2'b01;
      RESP:    bus.rsp_valid = id_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q    <= 1'b1;
      id_q            <= 1'b0;
      op_q            <= 3'b000;
      cnt_q           <= 2'd0;
      alu_in1_q       <= 32'd0;
      alu_in2_q       <= 32'd0;
      alu_binvert_q   <= 1'b0;
      alu_cin_q       <= 1'b0;
      alu_operation_q <= 2'b00;
      rsp_result_q    <= 32'd0;
      rsp_carry_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      rsp_zero_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          id_q         <= gnt;
          op_q         <= sel_op;
          last_grant_q <= gnt;
          cnt_q        <= CNT_INIT;
          if (sel_dec[4]) begin
            alu_in1_q       <= sel_a;
            alu_in2_q       <= sel_b;
            alu_binvert_q   <= sel_dec[3];
            alu_cin_q       <= sel_dec[2];
            alu_operation_q <= sel_dec[1:0];
          end else begin
            // reserved op: ALU drive is left untouched, error response goes out directly
            rsp_result_q <= 32'd0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b1;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero_q   <= 1'b1;
`endif
          end
        end
        EXEC: begin
          if (cnt_q == 2'd0) begin
            rsp_result_q <= cap_result;
            rsp_carry_q  <= cap_carry;
            rsp_err_q    <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
            rsp_zero_q   <= (cap_result == 32'd0);
`endif
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: if (rsp_hs) begin
          rsp_result_q <= 32'd0;
          rsp_carry_q  <= 1'b0;
          rsp_err_q    <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
          rsp_zero_q   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign alu_in1_o       = alu_in1_q;
  assign alu_in2_o       = alu_in2_q;
  assign alu_binvert_o   = alu_binvert_q;
  assign alu_cin_o       = alu_cin_q;
  assign alu_operation_o = alu_operation_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_carry   = rsp_carry_q;
  assign bus.rsp_err     = rsp_err_q;
`ifdef ALU_ZERO_FLAG_EN
  assign bus.rsp_zero    = rsp_zero_q;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: three instances (round-robin/SETTLE=1, strict/SETTLE=1, SETTLE=4)
// each driving a behavioural ALU; results checked against an op-level reference model.
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  alu_share_if ifa();
  alu_share_if ifb();
  alu_share_if ifc();

  logic [31:0] a_in1, a_in2, a_res, b_in1, b_in2, b_res, c_in1, c_in2, c_res;
  logic        a_binv, a_cin, a_carry, b_binv, b_cin, b_carry, c_binv, c_cin, c_carry;
  logic [1:0]  a_op, b_op, c_op;
`ifdef ALU_ZERO_FLAG_EN
  logic        last_zero;
`endif

  function automatic logic [32:0] alu_model(input logic [31:0] x, y, input logic binv, cin,
                                            input logic [1:0] op);
    logic [31:0] yy;
    logic [32:0] s;
    yy = binv ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + {32'd0, cin};
    case (op)
      2'b00:   return {s[32], x & yy};
      2'b01:   return {s[32], x | yy};
      default: return s;
    endcase
  endfunction

  assign {a_carry, a_res} = alu_model(a_in1, a_in2, a_binv, a_cin, a_op);
  assign {b_carry, b_res} = alu_model(b_in1, b_in2, b_binv, b_cin, b_op);
  assign {c_carry, c_res} = alu_model(c_in1, c_in2, c_binv, c_cin, c_op);

  alu_share_ctrl #(.SETTLE(1), .STRICT_PRIO(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .alu_in1_o(a_in1), .alu_in2_o(a_in2), .alu_binvert_o(a_binv), .alu_cin_o(a_cin),
    .alu_operation_o(a_op), .alu_result_i(a_res), .alu_carry_i(a_carry));

  alu_share_ctrl #(.SETTLE(1), .STRICT_PRIO(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .alu_in1_o(b_in1), .alu_in2_o(b_in2), .alu_binvert_o(b_binv), .alu_cin_o(b_cin),
    .alu_operation_o(b_op), .alu_result_i(b_res), .alu_carry_i(b_carry));

  alu_share_ctrl #(.SETTLE(4), .STRICT_PRIO(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc),
    .alu_in1_o(c_in1), .alu_in2_o(c_in2), .alu_binvert_o(c_binv), .alu_cin_o(c_cin),
    .alu_operation_o(c_op), .alu_result_i(c_res), .alu_carry_i(c_carry));

  // Reference: what each op code means, independent of how the ALU is steered.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, b,
                                 output logic [31:0] res, output logic carry, err,
                                 output logic [3:0] ctrl);
    logic [32:0] w;
    res = 32'd0; carry = 1'b0; err = 1'b0; ctrl = 4'b0000;
    case (op)
      3'b000: begin res = a & b; ctrl = 4'b0000; end
      3'b001: begin res = a | b; ctrl = 4'b0001; end
      3'b010: begin w = {1'b0, a} + {1'b0, b}; res = w[31:0]; carry = w[32]; ctrl = 4'b0010; end
      3'b110: begin res = a - b; carry = (a >= b); ctrl = 4'b1110; end
      3'b111: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ctrl = 4'b1110; end
      default: err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] corner(input int k);
    case (k)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [2:0] pick_op(input int k);
    case (k)
      0: return 3'b000; 1: return 3'b001; 2: return 3'b010; 3: return 3'b110;
      4: return 3'b111; 5: return 3'b011; 6: return 3'b100; default: return 3'b101;
    endcase
  endfunction

  // Drives one op on instance A and completes the response handshake (no checking here).
  task automatic run_a(input int r, input logic [2:0] op, input logic [31:0] a, b,
                       output logic [31:0] res, output logic carry, err,
                       output logic [3:0] ctrl, output logic [31:0] in1, in2,
                       output int lat, output logic [1:0] rv);
    int n;
    @(negedge clk);
    if (r == 0) begin ifa.req_op0 = op; ifa.req_a0 = a; ifa.req_b0 = b; ifa.req_valid = 2'b01; end
    else        begin ifa.req_op1 = op; ifa.req_a1 = a; ifa.req_b1 = b; ifa.req_valid = 2'b10; end
    n = 0;
    #1;
    while (ifa.req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    ifa.req_valid = 2'b00;
    ctrl = {a_binv, a_cin, a_op};
    in1  = a_in1;
    in2  = a_in2;
    lat  = 1;
    while (ifa.rsp_valid == 2'b00 && lat < 20) begin @(negedge clk); lat++; end
    rv    = ifa.rsp_valid;
    res   = ifa.rsp_result;
    carry = ifa.rsp_carry;
    err   = ifa.rsp_err;
`ifdef ALU_ZERO_FLAG_EN
    last_zero = ifa.rsp_zero;
`endif
    ifa.rsp_ready = (r == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    ifa.rsp_ready = 2'b00;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ifa.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", ifa.req_ready); end
    checks++; if (ifa.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", ifa.rsp_valid); end
    checks++; if ({ifa.rsp_result, ifa.rsp_carry, ifa.rsp_err} !== 34'd0) begin errors++; $display("FAIL reset_rsp: got %h/%b/%b want 0", ifa.rsp_result, ifa.rsp_carry, ifa.rsp_err); end
    checks++; if ({a_in1, a_in2, a_binv, a_cin, a_op} !== 68'd0) begin errors++; $display("FAIL reset_alu: got %h %h %b want 0", a_in1, a_in2, {a_binv, a_cin, a_op}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] res, in1, in2; logic carry, err; logic [3:0] ctrl; int lat; logic [1:0] rv;
    run_a(0, 3'b010, 32'd5, 32'd7, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if (ctrl !== 4'b0010) begin errors++; $display("FAIL add_ctrl: got %b want 0010", ctrl); end
    checks++; if (lat != 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    checks++; if (rv !== 2'b01) begin errors++; $display("FAIL add_rsp_valid: got %b want 01", rv); end
    checks++; if ({res, carry} !== {32'd12, 1'b0}) begin errors++; $display("FAIL add_result: got %h/%b want 0000000c/0", res, carry); end
    checks++; if (ifa.rsp_valid !== 2'b00) begin errors++; $display("FAIL add_rsp_cleared: got %b want 00", ifa.rsp_valid); end

    run_a(1, 3'b110, 32'd3, 32'd5, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if (ctrl !== 4'b1110) begin errors++; $display("FAIL sub_ctrl: got %b want 1110", ctrl); end
    checks++; if (rv !== 2'b10) begin errors++; $display("FAIL sub_rsp_valid: got %b want 10", rv); end
    checks++; if ({res, carry} !== {32'hFFFF_FFFE, 1'b0}) begin errors++; $display("FAIL sub_result: got %h/%b want fffffffe/0", res, carry); end

    run_a(0, 3'b111, 32'h8000_0000, 32'd1, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if ({res, carry} !== {32'd1, 1'b0}) begin errors++; $display("FAIL slt_neg_pos: got %h/%b want 00000001/0", res, carry); end
    run_a(1, 3'b111, 32'd1, 32'h8000_0000, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if ({res, carry} !== {32'd0, 1'b0}) begin errors++; $display("FAIL slt_pos_neg: got %h/%b want 00000000/0", res, carry); end

    run_a(0, 3'b010, 32'hFFFF_FFFF, 32'd1, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if ({res, carry} !== {32'd0, 1'b1}) begin errors++; $display("FAIL add_wrap: got %h/%b want 00000000/1", res, carry); end
`ifdef ALU_ZERO_FLAG_EN
    checks++; if (last_zero !== 1'b1) begin errors++; $display("FAIL add_wrap_zero: got %b want 1", last_zero); end
`endif
  endtask

  task automatic test_reserved();
    logic [31:0] res, in1, in2; logic carry, err; logic [3:0] ctrl; int lat; logic [1:0] rv;
    run_a(0, 3'b001, 32'h11, 32'h22, res, carry, err, ctrl, in1, in2, lat, rv);
    run_a(1, 3'b011, 32'hAAAA, 32'h5555, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if ({err, res} !== {1'b1, 32'd0}) begin errors++; $display("FAIL rsvd_err_result: got %b/%h want 1/00000000", err, res); end
    checks++; if (lat != 1) begin errors++; $display("FAIL rsvd_latency: got %0d want 1", lat); end
    checks++; if ({ctrl, in1, in2} !== {4'b0001, 32'h11, 32'h22}) begin errors++; $display("FAIL rsvd_alu_hold: got %b %h %h want 0001 11 22", ctrl, in1, in2); end
  endtask

  task automatic test_random();
    logic [31:0] res, in1, in2, a, b, e_res, h_in1, h_in2; logic carry, err, e_carry, e_err;
    logic [3:0] ctrl, e_ctrl, h_ctrl; int lat, r; logic [2:0] op; logic [1:0] rv;
    pulse_reset();
    h_in1 = 32'd0; h_in2 = 32'd0; h_ctrl = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 1));
      op = pick_op(int'($urandom_range(0, 7)));
      a  = ($urandom_range(0, 3) == 0) ? corner(int'($urandom_range(0, 4))) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner(int'($urandom_range(0, 4))) : $urandom;
      ref_op(op, a, b, e_res, e_carry, e_err, e_ctrl);
      if (!e_err) begin h_in1 = a; h_in2 = b; h_ctrl = e_ctrl; end
      run_a(r, op, a, b, res, carry, err, ctrl, in1, in2, lat, rv);
      checks++; if ({res, carry, err} !== {e_res, e_carry, e_err}) begin errors++; $display("FAIL rand_rsp[%0d] op=%b a=%h b=%h: got %h/%b/%b want %h/%b/%b", i, op, a, b, res, carry, err, e_res, e_carry, e_err); end
      checks++; if ({ctrl, in1, in2} !== {h_ctrl, h_in1, h_in2}) begin errors++; $display("FAIL rand_alu[%0d]: got %b %h %h want %b %h %h", i, ctrl, in1, in2, h_ctrl, h_in1, h_in2); end
      checks++; if (lat != (e_err ? 1 : 2) || rv !== ((r == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rand_timing[%0d]: got lat=%0d rv=%b want lat=%0d req=%0d", i, lat, rv, e_err ? 1 : 2, r); end
    end
  endtask

  task automatic test_stall();
    int n;
    @(negedge clk);
    ifa.req_op0 = 3'b010; ifa.req_a0 = 32'h1234; ifa.req_b0 = 32'h1111; ifa.req_valid = 2'b01;
    n = 0; #1;
    while (ifa.req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    ifa.req_op1 = 3'b001; ifa.req_a1 = 32'hF0; ifa.req_b1 = 32'h0F; ifa.req_valid = 2'b10;
    ifa.rsp_ready = 2'b10;
    n = 0;
    while (ifa.rsp_valid == 2'b00 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      checks++; if ({ifa.rsp_valid, ifa.req_ready, ifa.rsp_result} !== {2'b01, 2'b00, 32'h2345}) begin errors++; $display("FAIL stall[%0d]: got valid=%b ready=%b result=%h want 01 00 2345", k, ifa.rsp_valid, ifa.req_ready, ifa.rsp_result); end
      @(negedge clk);
    end
    ifa.rsp_ready = 2'b01;
    @(negedge clk);
    ifa.rsp_ready = 2'b00;
    checks++; if ({ifa.rsp_valid, ifa.req_ready, ifa.rsp_result} !== {2'b00, 2'b10, 32'd0}) begin errors++; $display("FAIL stall_release: got valid=%b ready=%b result=%h want 00 10 0", ifa.rsp_valid, ifa.req_ready, ifa.rsp_result); end
    @(negedge clk);
    ifa.req_valid = 2'b00;
    @(negedge clk);
    checks++; if ({ifa.rsp_valid, ifa.rsp_result} !== {2'b10, 32'hFF}) begin errors++; $display("FAIL stall_next: got valid=%b result=%h want 10 ff", ifa.rsp_valid, ifa.rsp_result); end
    ifa.rsp_ready = 2'b10;
    @(negedge clk);
    ifa.rsp_ready = 2'b00;
  endtask

  task automatic test_back_to_back();
    int g[$]; int t[$]; int cyc, got, exp_g;
    pulse_reset();
    ifa.req_op0 = 3'b010; ifa.req_a0 = 32'd1; ifa.req_b0 = 32'd1;
    ifa.req_op1 = 3'b010; ifa.req_a1 = 32'd2; ifa.req_b1 = 32'd2;
    ifa.rsp_ready = 2'b11; ifa.req_valid = 2'b11;
    cyc = 0;
    while (g.size() < 4 && cyc < 40) begin
      #1;
      if (ifa.req_ready != 2'b00) begin g.push_back(int'(ifa.req_ready[1])); t.push_back(cyc); end
      @(negedge clk); cyc++;
    end
    ifa.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    ifa.rsp_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      got = (i < g.size()) ? g[i] : -1;
      exp_g = i % 2;
      checks++; if (got != exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, got, exp_g); end
    end
    for (int i = 1; i < 4; i++) begin
      got = (i < t.size()) ? t[i] - t[i-1] : -1;
      checks++; if (got != 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d want 3", i, got); end
    end
  endtask

  task automatic test_strict_prio();
    int g[$]; int cyc, got;
    @(negedge clk);
    ifb.req_op0 = 3'b010; ifb.req_a0 = 32'd1; ifb.req_b0 = 32'd2;
    ifb.req_op1 = 3'b001; ifb.req_a1 = 32'd4; ifb.req_b1 = 32'd8;
    ifb.rsp_ready = 2'b11; ifb.req_valid = 2'b11;
    cyc = 0;
    while (g.size() < 3 && cyc < 40) begin
      #1;
      if (ifb.req_ready != 2'b00) g.push_back(int'(ifb.req_ready[1]));
      @(negedge clk); cyc++;
    end
    ifb.req_valid = 2'b00;
    repeat (4) @(negedge clk);
    ifb.rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      got = (i < g.size()) ? g[i] : -1;
      checks++; if (got != 0) begin errors++; $display("FAIL strict_grant[%0d]: got %0d want 0", i, got); end
    end
  endtask

  task automatic test_settle4();
    int n;
    @(negedge clk);
    ifc.req_op0 = 3'b110; ifc.req_a0 = 32'd100; ifc.req_b0 = 32'd1; ifc.req_valid = 2'b01;
    n = 0; #1;
    while (ifc.req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      ifc.req_valid = 2'b00;
      checks++; if ({c_in1, c_in2, c_binv, c_cin, c_op, ifc.rsp_valid} !== {32'd100, 32'd1, 4'b1110, 2'b00}) begin errors++; $display("FAIL settle4_exec[%0d]: got %h %h %b valid=%b want 64 1 1110 00", k, c_in1, c_in2, {c_binv, c_cin, c_op}, ifc.rsp_valid); end
    end
    @(negedge clk);
    checks++; if ({ifc.rsp_valid, ifc.rsp_result, ifc.rsp_carry} !== {2'b01, 32'd99, 1'b1}) begin errors++; $display("FAIL settle4_rsp: got valid=%b %h/%b want 01 63/1", ifc.rsp_valid, ifc.rsp_result, ifc.rsp_carry); end
    ifc.rsp_ready = 2'b01;
    @(negedge clk);
    ifc.rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    int n;
    logic [31:0] res, in1, in2; logic carry, err; logic [3:0] ctrl; int lat; logic [1:0] rv;
    @(negedge clk);
    ifa.req_op0 = 3'b010; ifa.req_a0 = 32'd9; ifa.req_b0 = 32'd9; ifa.req_valid = 2'b01;
    n = 0; #1;
    while (ifa.req_ready == 2'b00 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    ifa.req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    checks++; if ({ifa.req_ready, ifa.rsp_valid, ifa.rsp_result, ifa.rsp_carry, ifa.rsp_err} !== 38'd0) begin errors++; $display("FAIL rst_mid_rsp: got ready=%b valid=%b result=%h", ifa.req_ready, ifa.rsp_valid, ifa.rsp_result); end
    checks++; if ({a_in1, a_in2, a_binv, a_cin, a_op} !== 68'd0) begin errors++; $display("FAIL rst_mid_alu: got %h %h %b want 0", a_in1, a_in2, {a_binv, a_cin, a_op}); end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (ifa.rsp_valid != 2'b00) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d response cycles want 0", n); end
    run_a(0, 3'b010, 32'd2, 32'd3, res, carry, err, ctrl, in1, in2, lat, rv);
    checks++; if ({res, lat} !== {32'd5, 32'd2}) begin errors++; $display("FAIL rst_mid_recover: got %h lat=%0d want 5 lat=2", res, lat); end
  endtask

  initial begin
    rst_n = 1'b0;
    ifa.req_valid = 2'b00; ifa.rsp_ready = 2'b00;
    ifa.req_op0 = 3'b000; ifa.req_op1 = 3'b000;
    ifa.req_a0 = 32'd0; ifa.req_a1 = 32'd0; ifa.req_b0 = 32'd0; ifa.req_b1 = 32'd0;
    ifb.req_valid = 2'b00; ifb.rsp_ready = 2'b00;
    ifb.req_op0 = 3'b000; ifb.req_op1 = 3'b000;
    ifb.req_a0 = 32'd0; ifb.req_a1 = 32'd0; ifb.req_b0 = 32'd0; ifb.req_b1 = 32'd0;
    ifc.req_valid = 2'b00; ifc.rsp_ready = 2'b00;
    ifc.req_op0 = 3'b000; ifc.req_op1 = 3'b000;
    ifc.req_a0 = 32'd0; ifc.req_a1 = 32'd0; ifc.req_b0 = 32'd0; ifc.req_b1 = 32'd0;
    test_reset();
    test_directed();
    test_reserved();
    test_stall();
    test_back_to_back();
    test_strict_prio();
    test_settle4();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
